// File: rtl/mem_port_arbiter_if.sv
// Bundle of the data-path, fetch and memory-port signals shared by the arbiter.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 64
`endif

interface mem_port_arbiter_if;
    logic                d_req;
    logic [`ADDR_W-1:0]  d_addr;
    logic [7:0]          d_we;
    logic [`REG_W-1:0]   d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [`REG_W-1:0]   d_rdata;

    logic                f_req;
    logic [`ADDR_W-1:0]  f_addr;
    logic                f_gnt;
    logic                f_rvalid;
    logic [`REG_W-1:0]   f_rdata;
    logic                f_flush;

    logic                mem_en;
    logic [`ADDR_W-1:0]  mem_addr;
    logic [7:0]          mem_we;
    logic [`REG_W-1:0]   mem_wdata;
    logic [`REG_W-1:0]   mem_rdata;

    // requesters and memory side
    modport master (
        output d_req, d_addr, d_we, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output f_req, f_addr, f_flush,
        input  f_gnt, f_rvalid, f_rdata,
        input  mem_en, mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    // arbiter side
    modport slave (
        input  d_req, d_addr, d_we, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  f_req, f_addr, f_flush,
        output f_gnt, f_rvalid, f_rdata,
        output mem_en, mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the data path and instruction fetch,
// registering the winner onto mem_* and steering read returns via a tag pipeline.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 64
`endif

module mem_port_arbiter #(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rstn,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic valid;
        logic port;   // 1 = fetch, 0 = data
    } tag_t;

    logic                 d_gnt;
    logic                 f_gnt;
    logic [CNT_W-1:0]     starve_cnt;
    logic [CNT_W-1:0]     starve_cnt_next;
    tag_t                 tag_in;
    tag_t [LOAD_LATENCY:0] tags;

    logic                 mem_en_reg;
    logic [`ADDR_W-1:0]   mem_addr_reg;
    logic [7:0]           mem_we_reg;
    logic [`REG_W-1:0]    mem_wdata_reg;

    // A flush invalidates any fetch tag passing through a pipeline stage.
    function automatic tag_t scrub(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && t.port) r.valid = 1'b0;
        return r;
    endfunction

    // Grant selection: data wins unless fetch has starved to the limit; flush blocks fetch.
    always_comb begin
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        if (!rstn) begin
            d_gnt = 1'b0;
            f_gnt = 1'b0;
        end else if (bus.f_flush) begin
            d_gnt = bus.d_req;
        end else if (bus.d_req && bus.f_req && starve_cnt == CNT_W'(STARVE_LIMIT)) begin
            f_gnt = 1'b1;
        end else begin
            d_gnt = bus.d_req;
            f_gnt = bus.f_req && !bus.d_req;
        end
    end

    // Starvation counter next value and the tag for this cycle's winner.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (f_gnt || !bus.f_req) begin
            starve_cnt_next = '0;
        end else if (d_gnt && !bus.f_flush && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
        end
        tag_in.valid = (d_gnt && bus.d_we == '0) || f_gnt;
        tag_in.port  = f_gnt;
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rstn) starve_cnt <= '0;
        else       starve_cnt <= starve_cnt_next;
    end

    // Memory port register: winner's fields; address and store data hold when idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_en_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_en_reg <= d_gnt || f_gnt;
            if (d_gnt) begin
                mem_addr_reg  <= bus.d_addr;
                mem_we_reg    <= bus.d_we;
                mem_wdata_reg <= bus.d_wdata;
            end else if (f_gnt) begin
                mem_addr_reg <= bus.f_addr;
                mem_we_reg   <= '0;
            end else begin
                mem_we_reg <= '0;
            end
        end
    end

    // Tag pipeline tracking in-flight reads until their data returns.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tags <= '0;
        end else begin
            tags[0] <= scrub(tag_in, bus.f_flush);
            for (int unsigned k = 1; k <= LOAD_LATENCY; k++) begin
                tags[k] <= scrub(tags[k-1], bus.f_flush);
            end
        end
    end

    assign bus.d_gnt     = d_gnt;
    assign bus.f_gnt     = f_gnt;
    assign bus.d_rvalid  = tags[LOAD_LATENCY].valid && !tags[LOAD_LATENCY].port;
    assign bus.f_rvalid  = tags[LOAD_LATENCY].valid && tags[LOAD_LATENCY].port && !bus.f_flush;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.f_rdata   = bus.mem_rdata;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LOAD_LATENCY 1, 2, 3) share one
// stimulus; a return-schedule model checks every cycle, directed checks pin it.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 64
`endif

module tb_mem_port_arbiter;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic               d_req;
    logic [`ADDR_W-1:0] d_addr;
    logic [7:0]         d_we;
    logic [`REG_W-1:0]  d_wdata;
    logic               f_req;
    logic [`ADDR_W-1:0] f_addr;
    logic               f_flush;
    logic [`REG_W-1:0]  mem_rdata;

    logic [2:0]         o_dgnt, o_fgnt, o_drv, o_frv, o_men;
    logic [`ADDR_W-1:0] o_maddr [3];
    logic [7:0]         o_mwe   [3];
    logic [`REG_W-1:0]  o_mwd   [3];
    logic [`REG_W-1:0]  o_drd   [3];
    logic [`REG_W-1:0]  o_frd   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter_if bus ();
        assign bus.d_req     = d_req;
        assign bus.d_addr    = d_addr;
        assign bus.d_we      = d_we;
        assign bus.d_wdata   = d_wdata;
        assign bus.f_req     = f_req;
        assign bus.f_addr    = f_addr;
        assign bus.f_flush   = f_flush;
        assign bus.mem_rdata = mem_rdata;
        assign o_dgnt[g]  = bus.d_gnt;
        assign o_fgnt[g]  = bus.f_gnt;
        assign o_drv[g]   = bus.d_rvalid;
        assign o_frv[g]   = bus.f_rvalid;
        assign o_men[g]   = bus.mem_en;
        assign o_maddr[g] = bus.mem_addr;
        assign o_mwe[g]   = bus.mem_we;
        assign o_mwd[g]   = bus.mem_wdata;
        assign o_drd[g]   = bus.d_rdata;
        assign o_frd[g]   = bus.f_rdata;
        mem_port_arbiter #(.LOAD_LATENCY(g + 1), .STARVE_LIMIT(SL)) dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Returns are scheduled by cycle number; fetch waiting is a plain counter.
    int                 cyc = 0;
    bit [7:0]           sched_d [3];
    bit [7:0]           sched_f [3];
    int                 m_wait  [3];
    logic               m_en    [3];
    logic [`ADDR_W-1:0] m_addr  [3];
    logic [7:0]         m_we    [3];
    logic [`REG_W-1:0]  m_wd    [3];
    int                 ll, slot;
    logic               e_d, e_f;

    initial begin
        for (int g = 0; g < 3; g++) begin
            sched_d[g] = '0; sched_f[g] = '0; m_wait[g] = 0;
            m_en[g] = 1'b0; m_addr[g] = '0; m_we[g] = '0; m_wd[g] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            ll   = g + 1;
            slot = cyc % 8;
            e_d  = 1'b0;
            e_f  = 1'b0;
            if (rstn) begin
                if (f_flush) e_d = d_req;
                else if (d_req && f_req && m_wait[g] == SL) e_f = 1'b1;
                else begin
                    e_d = d_req;
                    e_f = f_req && !d_req;
                end
            end
            check($sformatf("L%0d c%0d d_gnt", ll, cyc), o_dgnt[g], e_d);
            check($sformatf("L%0d c%0d f_gnt", ll, cyc), o_fgnt[g], e_f);
            check($sformatf("L%0d c%0d d_rvalid", ll, cyc), o_drv[g], sched_d[g][slot]);
            check($sformatf("L%0d c%0d f_rvalid", ll, cyc), o_frv[g], sched_f[g][slot] && !f_flush);
            check($sformatf("L%0d c%0d mem_en", ll, cyc), o_men[g], m_en[g]);
            check($sformatf("L%0d c%0d mem_addr", ll, cyc), o_maddr[g], m_addr[g]);
            check($sformatf("L%0d c%0d mem_we", ll, cyc), o_mwe[g], m_we[g]);
            check($sformatf("L%0d c%0d mem_wdata", ll, cyc), o_mwd[g], m_wd[g]);
            check($sformatf("L%0d c%0d d_rdata", ll, cyc), o_drd[g], mem_rdata);
            check($sformatf("L%0d c%0d f_rdata", ll, cyc), o_frd[g], mem_rdata);

            sched_d[g][slot] = 1'b0;
            sched_f[g][slot] = 1'b0;
            if (f_flush) sched_f[g] = '0;
            if (!rstn) begin
                sched_d[g] = '0; sched_f[g] = '0; m_wait[g] = 0;
                m_en[g] = 1'b0; m_addr[g] = '0; m_we[g] = '0; m_wd[g] = '0;
            end else begin
                if (e_d && d_we == 8'h00) sched_d[g][(cyc + 1 + ll) % 8] = 1'b1;
                if (e_f) sched_f[g][(cyc + 1 + ll) % 8] = 1'b1;
                m_en[g] = e_d || e_f;
                if (e_d) begin
                    m_addr[g] = d_addr; m_we[g] = d_we; m_wd[g] = d_wdata;
                end else if (e_f) begin
                    m_addr[g] = f_addr; m_we[g] = 8'h00;
                end else begin
                    m_we[g] = 8'h00;
                end
                if (e_f || !f_req) m_wait[g] = 0;
                else if (e_d && !f_flush && m_wait[g] < SL) m_wait[g]++;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic dr, input logic [31:0] da, input logic [7:0] dw,
                         input logic [63:0] dd, input logic fr, input logic [31:0] fa,
                         input logic fl);
        d_req = dr; d_addr = da; d_we = dw; d_wdata = dd;
        f_req = fr; f_addr = fa; f_flush = fl;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin
            @(negedge clk);
            to_next();
        end
    endtask

    initial begin
        rstn = 1'b0;
        mem_rdata = 64'hA5A5_0000_5A5A_FFFF;
        drive(1, 32'h20, 8'h00, 64'h0, 1, 32'h40, 0);

        // reset held with both requesting
        repeat (3) begin
            @(negedge clk);
            check("rst d_gnt", o_dgnt[0], 0);
            check("rst f_gnt", o_fgnt[0], 0);
            check("rst mem_en", o_men[0], 0);
            check("rst mem_we", o_mwe[0], 0);
            check("rst d_rvalid", o_drv[0], 0);
            check("rst f_rvalid", o_frv[0], 0);
            to_next();
        end
        rstn = 1'b1;

        // starvation: d,d,d,d,f,d then fetch return one cycle after mem_*
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            check($sformatf("starve s%0d d_gnt", s), o_dgnt[0], s != 4);
            check($sformatf("starve s%0d f_gnt", s), o_fgnt[0], s == 4);
            if (s == 5) begin
                check("starve mem_addr", o_maddr[0], 32'h40);
                check("starve mem_we", o_mwe[0], 8'h00);
            end
            to_next();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("starve f_rvalid", o_frv[0], 1);
        check("starve d_rvalid", o_drv[0], 0);
        to_next();
        idle(5);

        // single read, LOAD_LATENCY=1
        drive(1, 32'h10, 8'h00, 64'h0, 0, 0, 0);
        @(negedge clk);
        check("read d_gnt", o_dgnt[0], 1);
        to_next();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("read mem_en", o_men[0], 1);
        check("read mem_addr", o_maddr[0], 32'h10);
        to_next();
        mem_rdata = 64'hDEADBEEF_00000001;
        @(negedge clk);
        check("read d_rvalid", o_drv[0], 1);
        check("read d_rdata", o_drd[0], 64'hDEADBEEF_00000001);
        check("read f_rvalid", o_frv[0], 0);
        to_next();
        idle(4);

        // store
        drive(1, 32'h18, 8'hF0, 64'h1122334455667788, 0, 0, 0);
        @(negedge clk);
        check("store d_gnt", o_dgnt[0], 1);
        to_next();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("store mem_we", o_mwe[0], 8'hF0);
        check("store mem_wdata", o_mwd[0], 64'h1122334455667788);
        to_next();
        @(negedge clk);
        check("store d_rvalid", o_drv[0], 0);
        to_next();
        idle(4);

        // data write and fetch read together: write first, fetch next cycle
        drive(1, 32'h50, 8'hFF, 64'h0BAD_F00D_0BAD_F00D, 1, 32'h60, 0);
        @(negedge clk);
        check("wf d_gnt", o_dgnt[0], 1);
        check("wf f_gnt", o_fgnt[0], 0);
        to_next();
        drive(0, 0, 0, 0, 1, 32'h60, 0);
        @(negedge clk);
        check("wf f_gnt2", o_fgnt[0], 1);
        to_next();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wf mem_addr", o_maddr[0], 32'h60);
        check("wf mem_we", o_mwe[0], 8'h00);
        to_next();
        idle(5);

        // flush sequence (LOAD_LATENCY=3 pinned; LOAD_LATENCY=1 partly)
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: drive(0, 0, 0, 0, 1, 32'h100, 0);
                1: drive(0, 0, 0, 0, 1, 32'h104, 0);
                2: drive(1, 32'h200, 8'h00, 0, 0, 0, 0);
                3: drive(0, 0, 0, 0, 0, 0, 1);
                4: drive(0, 0, 0, 0, 1, 32'h108, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            if (c == 3) check("flush L1 f_rvalid c3", o_frv[0], 0);
            if (c == 4) check("flush L1 d_rvalid c4", o_drv[0], 1);
            if (c == 4 || c == 5) check($sformatf("flush L3 f_rvalid c%0d", c), o_frv[2], 0);
            if (c == 6) check("flush L3 d_rvalid c6", o_drv[2], 1);
            if (c == 8) check("flush L3 f_rvalid c8", o_frv[2], 1);
            to_next();
        end
        idle(3);

        // reset mid-flight
        drive(1, 32'h30, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        check("midrst d_gnt", o_dgnt[1], 1);
        to_next();
        drive(0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        @(negedge clk);
        to_next();
        rstn = 1'b1;
        @(negedge clk);
        check("midrst mem_en", o_men[1], 0);
        to_next();
        @(negedge clk);
        check("midrst L2 d_rvalid", o_drv[1], 0);
        to_next();
        @(negedge clk);
        check("midrst L3 d_rvalid", o_drv[2], 0);
        to_next();
        idle(3);

        // mixed pattern, model-checked
        for (int i = 0; i < 40; i++) begin
            drive((i % 3) != 0, 32'h1000 + i, (i % 5 == 0) ? 8'h0F : 8'h00,
                  {32'hF00D0000, i}, (i % 2 == 0) || (i > 24), 32'h2000 + i, (i % 7) == 3);
            mem_rdata = {32'hBEEF0000, i};
            @(negedge clk);
            to_next();
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single physical data-memory port between the data path (load/store, already split into word address and byte enables) and the instruction-fetch unit. It grants at most one access per cycle and registers the winner onto the memory port. It tracks every in-flight read through a LOAD_LATENCY-deep tag pipeline so returned data is steered to the correct requester, and it supports a fetch-side flush that discards stale fetch returns.

## Interface
- LOAD_LATENCY, 1: cycles from an access driven on mem_* to its mem_rdata being valid (≥1).
- STARVE_LIMIT, 4: max consecutive data grants while fetch waits before fetch is forced a grant (≥1).
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- d_req  in  1  data port request.
- d_addr  in  `ADDR_W  data word address.
- d_we  in  8  data byte write enables; 0 means read.
- d_wdata  in  `REG_W  data store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read result valid.
- d_rdata  out  `REG_W  data read result.
- f_req  in  1  fetch request (always a read).
- f_addr  in  `ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read result valid.
- f_rdata  out  `REG_W  fetch read result.
- f_flush  in  1  discard all in-flight fetch reads; block fetch grant this cycle.
- mem_en  out  1  access valid on mem_*.
- mem_addr  out  `ADDR_W  registered word address.
- mem_we  out  8  registered byte enables.
- mem_wdata  out  `REG_W  registered store data.
- mem_rdata  in  `REG_W  memory read data.

## Operation
- Handshake: a transfer occurs when req & gnt in the same cycle. gnt is combinational from req, the counter state, and f_flush. The requester must hold its fields stable while req is high and gnt is low.
- Arbitration, evaluated each cycle:
  - rstn=0: both gnt=0.
  - f_flush=1: f_gnt=0; d_gnt=d_req.
  - Both requesting and starve_cnt==STARVE_LIMIT: f_gnt=1, d_gnt=0.
  - Otherwise data wins: d_gnt=d_req, f_gnt=f_req & ~d_req.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments when d_gnt & f_req & ~f_flush.
  - Clears to 0 on any f_gnt or when f_req=0.
  - Holds otherwise.
- Memory register, at each edge:
  - mem_en <= d_gnt|f_gnt.
  - mem_addr/mem_we/mem_wdata <= winner's fields; fetch drives mem_we=0.
  - With no grant, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their previous values.
- Tag pipeline tag[0..LOAD_LATENCY], each tag = {valid, port}:
  - tag[0] <= {winner is read, winner==fetch}; tag[k] <= tag[k-1].
  - Writes create no tag and never produce rvalid.
  - f_flush=1 clears valid on every fetch tag, including the one being shifted in. Data tags are unaffected.
- Return path:
  - d_rvalid = tag[LL].valid & ~tag[LL].port.
  - f_rvalid = tag[LL].valid & tag[LL].port & ~f_flush.
  - d_rdata = f_rdata = mem_rdata (unqualified).
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all tags invalid, starve_cnt=0; hence d_rvalid=f_rvalid=0 and both gnt=0.
- Reset mid-operation: in-flight reads are dropped silently; no rvalid appears after reset.

## Timing
- Grant in cycle N. mem_* valid in cycle N+1. mem_rdata and rvalid valid in cycle N+1+LOAD_LATENCY, so request-to-data latency is LOAD_LATENCY+1.
- Throughput: one access per cycle, back-to-back, any mix of ports. Returns come back in grant order.
- Store then load to the same address on consecutive grants: the load sees the stored data, because the memory applies writes in order on mem_*.
- f_flush in cycle M:
  - No f_rvalid in cycle M or later for fetches granted before M.
  - Fetches granted in M+1 onward return normally.
  - A data rvalid in cycle M is still delivered.
- Data write and fetch read in the same cycle with starve_cnt<limit: the data write is granted and fetch waits one cycle.

## Test plan
- Reset: hold rstn=0 for 3 cycles with d_req=f_req=1 -> gnt=0, mem_en=0, mem_we=0, rvalid=0 throughout; the first grant is in the first cycle after rstn rises.
- Single read, LOAD_LATENCY=1: d_req with d_addr=0x10, d_we=0 in cycle 0 -> d_gnt=1 in cycle 0, mem_en=1 and mem_addr=0x10 in cycle 1. Drive mem_rdata=0xDEADBEEF_00000001 in cycle 2 -> d_rvalid=1 with that data in cycle 2 and f_rvalid=0.
- Store: d_we=0xF0, d_wdata=0x1122334455667788 -> mem_we=0xF0 and mem_wdata as given one cycle later; no d_rvalid ever.
- Starvation, STARVE_LIMIT=4: d_req and f_req held high -> d_gnt in cycles 0-3, f_gnt in cycle 4, d_gnt resumes in cycle 5. f_rvalid in cycle 6 (LOAD_LATENCY=1).
- Flush, LOAD_LATENCY=3: fetch granted in cycles 0 and 1, data read granted in cycle 2, f_flush=1 in cycle 3 -> no f_rvalid in cycles 4-5; d_rvalid in cycle 6; a fetch granted in cycle 4 gives f_rvalid in cycle 8.
- Reset mid-flight: read granted in cycle 0 (LOAD_LATENCY=2), rstn=0 in cycle 1 -> no rvalid in cycle 3; starve_cnt and tags are 0 after reset.
